// File: rtl/pwm_spi_multichannel_pkg.sv
// Shared constants for the SPI-programmed multichannel PWM block:
// register map, frame length and the SPI frame layout.
package pwm_spi_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] OUT_EN_BASE   = 7'h00;
    localparam logic [6:0] PWM_EN_BASE   = 7'h08;
    localparam logic [6:0] DUTY_BASE     = 7'h10;
    localparam logic [6:0] PRESCALE_ADDR = 7'h60;

    // Bit counter saturates one past a full frame so long frames stay distinguishable.
    localparam int               BIT_CNT_W   = 5;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_SAT = 5'd17;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ONE = 5'd1;

    // One SPI frame as received, MSB first.
    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } spi_frame_t;

endpackage

// File: rtl/pwm_spi_multichannel_spi.sv
// Write-only SPI (mode 0) slave sampled in the system clock domain.
// Synchronises sclk/copi/ncs, shifts bits on synchronised sclk rising edges
// and emits a one-cycle write strobe when a frame of exactly FRAME_BITS bits
// with the write flag set closes.
module spi_write_slave
    import pwm_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       busy,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    spi_frame_t             shift_q, shift_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [6:0]             wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;

    logic sclk_s, copi_s, ncs_s, sclk_rise, ncs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;

    // Synchronisers and edge-detect history; ncs idles high so reset it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    // Shift/count while selected; qualify and latch the frame when ncs deasserts.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (ncs_s) begin
            // Holding the count at zero while deselected also restarts it on the next ncs fall.
            bit_cnt_d = '0;
            if (ncs_rise && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) && shift_q.wr) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = shift_q.addr;
                wr_data_d  = shift_q.data;
            end
        end else if (sclk_rise) begin
            shift_d = spi_frame_t'({shift_q[FRAME_BITS-2:0], copi_s});
            if (bit_cnt_q != BIT_CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_ONE;
            end
        end
    end

    // Frame state and write strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy     = ~ncs_s;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: rtl/pwm_spi_multichannel.sv
// Multichannel PWM driven by an SPI write-only register bank.
// Holds per-channel OUT_EN/PWM_EN/DUTY, a shared prescaler, the 8-bit period
// counter and one comparator per channel.
// Build option: define PWM_SHADOW_EN to double-buffer DUTY so new values only
// take effect at the period wrap (glitch-free); otherwise writes apply next clk.
module pwm_spi_multichannel
    import pwm_spi_pkg::*;
#(
    parameter int         NUM_CH       = 16,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] PRESCALE_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic [NUM_CH-1:0] ch_out,
    output logic              busy
);

    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    spi_write_slave #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .copi    (copi),
        .ncs     (ncs),
        .busy    (busy),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    logic [NUM_CH-1:0] out_en_q, out_en_d;
    logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
    logic [7:0]        duty_act_q [NUM_CH];
    logic [7:0]        duty_act_d [NUM_CH];
    logic [7:0]        prescale_q, prescale_d;
    logic [7:0]        pre_cnt_q, pre_cnt_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] ch_out_q, ch_out_d;
    logic [NUM_CH-1:0] pwm;
    logic              tick;

    assign tick = (pre_cnt_q == prescale_q);

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_shd_q [NUM_CH];
    logic [7:0] duty_shd_d [NUM_CH];
    logic       wrap;

    assign wrap = tick && (cnt_q == 8'hFF);
`endif

    // Register-bank decode plus prescale/period counter next state.
    always_comb begin
        out_en_d   = out_en_q;
        pwm_en_d   = pwm_en_q;
        duty_act_d = duty_act_q;
        prescale_d = prescale_q;
        pre_cnt_d  = tick ? 8'd0 : pre_cnt_q + 8'd1;
        cnt_d      = tick ? cnt_q + 8'd1 : cnt_q;
`ifdef PWM_SHADOW_EN
        duty_shd_d = duty_shd_q;
        // Wrap loads the shadow as it was before any same-cycle write.
        if (wrap) begin
            duty_act_d = duty_shd_q;
        end
`endif
        if (wr_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == OUT_EN_BASE + 7'(i / 8)) begin
                    out_en_d[i] = wr_data[i % 8];
                end
                if (wr_addr == PWM_EN_BASE + 7'(i / 8)) begin
                    pwm_en_d[i] = wr_data[i % 8];
                end
                if (wr_addr == DUTY_BASE + 7'(i)) begin
`ifdef PWM_SHADOW_EN
                    duty_shd_d[i] = wr_data;
`else
                    duty_act_d[i] = wr_data;
`endif
                end
            end
            if (wr_addr == PRESCALE_ADDR) begin
                prescale_d = wr_data;
                pre_cnt_d  = 8'd0;
            end
        end
    end

    // Per-channel comparators; full-scale duty forces a constant high.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign pwm[g] = (duty_act_q[g] == 8'hFF) ? 1'b1 : (cnt_q < duty_act_q[g]);
    end

    // Output gating: disabled -> 0, enabled without PWM -> 1, else PWM.
    always_comb begin
        ch_out_d = out_en_q & (~pwm_en_q | pwm);
    end

    // Register bank, counters and registered channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_q   <= '0;
            pwm_en_q   <= '0;
            prescale_q <= PRESCALE_RST;
            pre_cnt_q  <= '0;
            cnt_q      <= '0;
            ch_out_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_q[i] <= '0;
            end
        end else begin
            out_en_q   <= out_en_d;
            pwm_en_q   <= pwm_en_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            cnt_q      <= cnt_d;
            ch_out_q   <= ch_out_d;
            duty_act_q <= duty_act_d;
        end
    end

`ifdef PWM_SHADOW_EN
    // Shadow duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shd_q[i] <= '0;
            end
        end else begin
            duty_shd_q <= duty_shd_d;
        end
    end
`endif

    assign ch_out = ch_out_q;

endmodule

// File: tb/tb_pwm_spi_multichannel.sv
// Directed bench for pwm_spi_multichannel: SPI frames drive a register model;
// expected per-channel high counts over one PWM period are queued and checked.
module tb_pwm_spi_multichannel;

    localparam int NUM_CH      = 16;
    localparam int SYNC_STAGES = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk  = 1'b0;
    logic              copi  = 1'b0;
    logic              ncs   = 1'b1;
    logic [NUM_CH-1:0] ch_out;
    logic              busy;

    always #5 clk = ~clk;

    pwm_spi_multichannel #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .PRESCALE_RST(8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .copi  (copi),
        .ncs   (ncs),
        .ch_out(ch_out),
        .busy  (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        string tag;
        int    ch;
        int    exp;
    } exp_t;
    exp_t sb[$];

    // Reference register state
    bit m_oe [NUM_CH];
    bit m_pe [NUM_CH];
    int m_duty [NUM_CH];
    int m_ps;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clks(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_oe[c] = 1'b0; m_pe[c] = 1'b0; m_duty[c] = 0;
        end
        m_ps = 0;
    endfunction

    function automatic void model_write(int addr, logic [7:0] d);
        if (addr < 8) begin
            for (int j = 0; j < 8; j++) if (addr * 8 + j < NUM_CH) m_oe[addr * 8 + j] = d[j];
        end else if (addr < 16) begin
            for (int j = 0; j < 8; j++) if ((addr - 8) * 8 + j < NUM_CH) m_pe[(addr - 8) * 8 + j] = d[j];
        end else if (addr < 16 + NUM_CH) begin
            m_duty[addr - 16] = int'(d);
        end else if (addr == 96) begin
            m_ps = int'(d);
        end
    endfunction

    // High cycles of one channel over a full period of 256*(PRESCALE+1) clk.
    function automatic int model_high(int c);
        int p;
        p = 256 * (m_ps + 1);
        if (!m_oe[c]) return 0;
        if (!m_pe[c] || m_duty[c] == 255) return p;
        return m_duty[c] * (m_ps + 1);
    endfunction

    task automatic expect_ch(string tag, int c);
        exp_t e;
        e.tag = $sformatf("%s ch%0d", tag, c);
        e.ch  = c;
        e.exp = model_high(c);
        sb.push_back(e);
    endtask

    task automatic expect_all(string tag);
        for (int c = 0; c < NUM_CH; c++) expect_ch(tag, c);
    endtask

    // Count high cycles of every channel over one period, then drain the scoreboard.
    task automatic measure();
        int cnt [NUM_CH];
        int p;
        exp_t e;
        p = 256 * (m_ps + 1);
        for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
        clks(4);
        repeat (p) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) if (ch_out[c] === 1'b1) cnt[c]++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, 64'(cnt[e.ch]), 64'(e.exp));
        end
    endtask

    task automatic spi_begin();
        ncs = 1'b0;
        clks(4);
    endtask

    task automatic spi_bit(logic b);
        copi = b;
        clks(4);
        sclk = 1'b1;
        clks(4);
        sclk = 1'b0;
    endtask

    task automatic spi_end();
        clks(4);
        ncs = 1'b1;
        clks(SYNC_STAGES + 6);
    endtask

    // Send the n low bits of 'bits', MSB first.
    task automatic spi_raw(logic [16:0] bits, int n);
        spi_begin();
        for (int i = n - 1; i >= 0; i--) spi_bit(bits[i]);
        spi_end();
    endtask

    task automatic spi_write(int addr, int data);
        logic [16:0] f;
        f = {1'b0, 1'b1, 7'(addr), 8'(data)};
        spi_raw(f, 16);
        model_write(addr, 8'(data));
    endtask

    initial begin
        logic        prev;
        logic        found;
        logic [16:0] fr;

        model_reset();

        // Reset state
        clks(3);
        check("rst ch_out", 64'(ch_out), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        expect_all("rst");
        measure();

        // 1: channel 0 at 50 %, prescale 0
        spi_write(8'h00, 8'h01);
        spi_write(8'h08, 8'h01);
        spi_write(8'h10, 8'h80);
        spi_write(8'h60, 8'h00);
        expect_all("t1");
        measure();

        // 2: channel 3 duty extremes and PWM bypass
        spi_write(8'h00, 8'h09);
        spi_write(8'h08, 8'h09);
        spi_write(8'h13, 8'h00);
        expect_ch("t2 duty00", 3);
        expect_ch("t2 duty00", 0);
        measure();
        spi_write(8'h13, 8'hFF);
        expect_ch("t2 dutyFF", 3);
        measure();
        spi_write(8'h13, 8'h10);
        spi_write(8'h08, 8'h01);
        expect_ch("t2 pwm_off", 3);
        expect_ch("t2 pwm_off", 0);
        measure();

        // 3: malformed / read / unmapped frames are dropped; busy follows ncs
        spi_begin();
        check("t3 busy in frame", 64'(busy), 64'd1);
        fr = 17'h01000;
        for (int i = 14; i >= 0; i--) spi_bit(fr[i]);
        spi_end();
        check("t3 busy idle", 64'(busy), 64'd0);
        spi_raw(17'h19000, 17);
        spi_raw(17'h01000, 16);
        spi_write(8'h55, 8'hFF);
        expect_all("t3");
        measure();

        // 4: prescale 3 stretches the period to 1024 clk
        spi_write(8'h60, 8'h03);
        spi_write(8'h10, 8'h40);
        expect_all("t4");
        measure();

        // 5: DUTY write in the middle of a period
        spi_write(8'h10, 8'h80);
        clks(8);
        found = 1'b0;
        prev  = ch_out[0];
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (prev === 1'b0 && ch_out[0] === 1'b1) found = 1'b1;
            prev = ch_out[0];
        end
        check("t5 period start seen", 64'(found), 64'd1);
        spi_write(8'h10, 8'h20);
`ifdef PWM_SHADOW_EN
        check("t5 mid-period level", 64'(ch_out[0]), 64'd1);
`else
        check("t5 mid-period level", 64'(ch_out[0]), 64'd0);
`endif
        clks(1024);
        expect_ch("t5 next period", 0);
        measure();

        // 6: reset in the middle of a frame
        fr = 17'h080FF;
        spi_begin();
        for (int i = 15; i >= 7; i--) spi_bit(fr[i]);
        rst_n = 1'b0;
        model_reset();
        clks(2);
        check("t6 rst ch_out", 64'(ch_out), 64'd0);
        check("t6 rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        for (int i = 6; i >= 0; i--) spi_bit(fr[i]);
        spi_end();
        expect_all("t6 dropped");
        measure();
        spi_write(8'h00, 8'h01);
        spi_write(8'h08, 8'h01);
        spi_write(8'h10, 8'h80);
        expect_all("t6 recover");
        measure();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
